icache_fill_ctrl: RTL

//  Sequences the instruction cache. Serves IF fetch requests: a hit is answered from the cache lookup;
//  a miss refills over the shared byte-wide memory port. Four bytes are issued through the memory

---
 rtl/icache_fill_ctrl_pkg.sv | 18 +
 rtl/icache_fill_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types and constants for the instruction cache fill controller.
// Holds the FSM state encoding, byte count per instruction and bus types.
package icache_fill_ctrl_pkg;

    localparam int ICFC_ADDR_W    = 32;
    localparam int ICFC_INST_W    = 32;
    localparam int BYTES_PER_INST = 4;

    typedef logic [ICFC_ADDR_W-1:0] addr_t;
    typedef logic [ICFC_INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        ICFC_IDLE  = 2'd0,
        ICFC_FETCH = 2'd1,
        ICFC_RESP  = 2'd2
    } icfc_state_e;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Instruction cache sequencer: answers IF hits from the Icache lookup and
// refills misses byte-by-byte over the shared memory port.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = freeze), flush_in
//   if_req_valid/if_req_addr          : IF fetch request (held until pulse)
//   ic_hit/ic_hit_inst                : combinational Icache lookup result
//   ctrl_to_if_inst_valid/_inst       : registered one-cycle response to IF
//   ctrl_to_ic_fill_valid/_addr/_inst : registered one-cycle Icache write
//   mem_req_valid/mem_req_addr        : byte read request (decoded from state)
//   mem_grant, mem_din                : arbiter accept; byte one cycle later
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W = ICFC_ADDR_W,
    parameter int INST_W = ICFC_INST_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              ic_hit,
    input  logic [INST_W-1:0] ic_hit_inst,
    output logic              ctrl_to_if_inst_valid,
    output logic [INST_W-1:0] ctrl_to_if_inst,
    output logic              ctrl_to_ic_fill_valid,
    output logic [ADDR_W-1:0] ctrl_to_ic_fill_addr,
    output logic [INST_W-1:0] ctrl_to_ic_fill_inst,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_grant,
    input  logic [7:0]        mem_din
);

    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_INST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_INST - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_INST - 1);

    icfc_state_e state_q, state_d;

    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic              rcv_pend_q, rcv_pend_d;
    logic [ADDR_W-1:0] base_q, base_d;

    // Bytes 0..2 are stored; the last byte goes straight from mem_din
    // into the fill/response registers on the capture cycle.
    logic [BYTES_PER_INST-2:0][7:0] byte_q, byte_d;

    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fill_valid_q, fill_valid_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [INST_W-1:0] fill_inst_q, fill_inst_d;

    logic              req_fire;
    logic [INST_W-1:0] assembled;

    // No request is launched in a flush cycle: its byte would be dropped.
    assign mem_req_valid = rdy_in && !flush_in
                        && (state_q == ICFC_FETCH)
                        && (issue_cnt_q < CNT_FULL);
    assign mem_req_addr  = base_q + ADDR_W'(issue_cnt_q);
    assign req_fire      = mem_req_valid && mem_grant;
    assign assembled     = {mem_din, byte_q};

    assign ctrl_to_if_inst_valid = inst_valid_q;
    assign ctrl_to_if_inst       = inst_q;
    assign ctrl_to_ic_fill_valid = fill_valid_q;
    assign ctrl_to_ic_fill_addr  = fill_addr_q;
    assign ctrl_to_ic_fill_inst  = fill_inst_q;

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        rcv_pend_d   = rcv_pend_q;
        base_d       = base_q;
        byte_d       = byte_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_inst_d  = fill_inst_q;

        if (flush_in) begin
            state_d     = ICFC_IDLE;
            issue_cnt_d = '0;
            rcv_cnt_d   = '0;
            rcv_pend_d  = 1'b0;
        end else if (rdy_in) begin
            unique case (state_q)
                ICFC_IDLE: begin
                    if (if_req_valid) begin
                        if (ic_hit) begin
                            inst_d       = ic_hit_inst;
                            inst_valid_d = 1'b1;
                            state_d      = ICFC_RESP;
                        end else begin
                            base_d      = if_req_addr & ALIGN_MASK;
                            issue_cnt_d = '0;
                            rcv_cnt_d   = '0;
                            rcv_pend_d  = 1'b0;
                            state_d     = ICFC_FETCH;
                        end
                    end
                end
                ICFC_FETCH: begin
                    rcv_pend_d = req_fire;
                    if (req_fire) begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                    if (rcv_pend_q) begin
                        rcv_cnt_d = rcv_cnt_q + 1'b1;
                        for (int i = 0; i < BYTES_PER_INST - 1; i++) begin
                            if (rcv_cnt_q == CNT_W'(i)) begin
                                byte_d[i] = mem_din;
                            end
                        end
                        if (rcv_cnt_q == CNT_LAST) begin
                            inst_d       = assembled;
                            inst_valid_d = 1'b1;
                            fill_inst_d  = assembled;
                            fill_addr_d  = base_q;
                            fill_valid_d = 1'b1;
                            state_d      = ICFC_RESP;
                        end
                    end
                end
                ICFC_RESP: begin
                    state_d = ICFC_IDLE;
                end
                default: begin
                    state_d = ICFC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ICFC_IDLE;
            issue_cnt_q  <= '0;
            rcv_cnt_q    <= '0;
            rcv_pend_q   <= 1'b0;
            base_q       <= '0;
            byte_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            rcv_pend_q   <= rcv_pend_d;
            base_q       <= base_d;
            byte_q       <= byte_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_inst_q  <= fill_inst_d;
        end
    end

endmodule
